// File: rtl/rx_iq_capture_fifo.sv
// rx_iq_capture_fifo
// Capture buffer for decimated RX baseband pairs. It is armed by the CPU and
// runs either one-shot (stops after a programmed count) or continuously. The
// read port is first-word-fall-through, so the head pair is always presented on
// rd_data. Pairs that arrive while the FIFO is full are counted in a saturating
// overflow counter.
module rx_iq_capture_fifo #(
  parameter int DW    = 16,
  parameter int AW    = 10,
  parameter int OVF_W = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ce_down,
  input  logic [DW-1:0]     in_x,
  input  logic [DW-1:0]     in_y,
  input  logic              arm,
  input  logic              stop,
  input  logic              one_shot,
  input  logic [AW:0]       capture_len,
  input  logic              rd_en,
  output logic [2*DW-1:0]   rd_data,
  output logic              rd_valid,
  output logic [AW:0]       level,
  output logic              full,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic [1:0]        state
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Pair storage. Contents are never reset; level alone says what is valid.
  logic [2*DW-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg, level_next;
  logic [AW:0]      wr_count_reg, wr_count_inc;
  logic [AW:0]      len_reg;
  logic             one_shot_reg;
  logic             rd_valid_reg;
  logic [2*DW-1:0]  rd_data_reg;
  logic [OVF_W-1:0] ovf_reg;

  logic             capturing;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fetch;
  logic             last_write;
  logic [AW:0]      pending;

  // Datapath qualifiers. An arm cycle flushes everything, so it blocks all of them.
  always_comb begin
    capturing    = (state_reg == ST_CAPTURE);
    full         = (level_reg == DEPTH_L);
    pop          = rd_en & rd_valid_reg & ~arm;
    // While full, a push is allowed only if a pop frees the head slot in the same cycle.
    push         = capturing & ce_down & ~arm & (~full | pop);
    drop         = capturing & ce_down & ~arm & full & ~pop;
    // Pairs that are in RAM but not yet loaded into the output register.
    pending      = level_reg - (AW+1)'(rd_valid_reg);
    // Refill the output register when it is empty or being consumed.
    fetch        = (pending != '0) & (~rd_valid_reg | pop) & ~arm;
    wr_count_inc = wr_count_reg + (AW+1)'(1);
    last_write   = one_shot_reg & push & (wr_count_inc == len_reg);
    level_next   = level_reg + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Next-state logic for the capture FSM. Arm always wins over stop.
  always_comb begin
    state_next = state_reg;
    if (arm) begin
      state_next = ST_CAPTURE;
    end else begin
      case (state_reg)
        ST_CAPTURE: begin
          if (stop) begin
            state_next = ST_IDLE;
          end else if (last_write) begin
            state_next = ST_DONE;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // RAM write port. Write and read addresses never collide on an active slot
  // because the slot being overwritten when full has already been copied to rd_data.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_x, in_y};
    end
  end

  // Pointers, occupancy, output register and overflow accounting.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      wr_count_reg <= '0;
      len_reg      <= DEPTH_L;
      one_shot_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      ovf_reg      <= '0;
    end else if (arm) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      wr_count_reg <= '0;
      len_reg      <= (capture_len == '0) ? DEPTH_L : capture_len;
      one_shot_reg <= one_shot;
      rd_valid_reg <= 1'b0;
      ovf_reg      <= '0;
    end else begin
      level_reg <= level_next;
      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + AW'(1);
        wr_count_reg <= wr_count_inc;
      end
      if (fetch) begin
        rd_data_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        rd_valid_reg <= 1'b1;
      end else if (pop) begin
        rd_valid_reg <= 1'b0;
      end
      if (drop && (ovf_reg != {OVF_W{1'b1}})) begin
        ovf_reg <= ovf_reg + OVF_W'(1);
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign level    = level_reg;
  assign ovf_cnt  = ovf_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_rx_iq_capture_fifo.sv
// tb_rx_iq_capture_fifo
// Directed bench for rx_iq_capture_fifo with a 16-deep FIFO and a 3-bit
// overflow counter, so that both wrap and saturation are reachable quickly.
module tb_rx_iq_capture_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int OVF_W = 3;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce_down = 1'b0;
  logic [DW-1:0]     in_x = '0;
  logic [DW-1:0]     in_y = '0;
  logic              arm = 1'b0;
  logic              stop = 1'b0;
  logic              one_shot = 1'b0;
  logic [AW:0]       capture_len = '0;
  logic              rd_en = 1'b0;
  logic [2*DW-1:0]   rd_data;
  logic              rd_valid;
  logic [AW:0]       level;
  logic              full;
  logic [OVF_W-1:0]  ovf_cnt;
  logic [1:0]        state;

  int n_checks = 0;
  int n_errors = 0;

  rx_iq_capture_fifo #(.DW(DW), .AW(AW), .OVF_W(OVF_W)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .ce_down     (ce_down),
    .in_x        (in_x),
    .in_y        (in_y),
    .arm         (arm),
    .stop        (stop),
    .one_shot    (one_shot),
    .capture_len (capture_len),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .level       (level),
    .full        (full),
    .ovf_cnt     (ovf_cnt),
    .state       (state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] x, input logic [DW-1:0] y);
    in_x = x;
    in_y = y;
    ce_down = 1'b1;
    tick();
    ce_down = 1'b0;
    $display("push x=%0h y=%0h level=%0d ovf=%0d state=%0d", x, y, level, ovf_cnt, state);
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, rd_data, exp);
    $display("pop data=%0h level=%0d", rd_data, level);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_arm(input logic os, input logic [AW:0] len);
    one_shot = os;
    capture_len = len;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    $display("arm one_shot=%0d len=%0d", os, len);
  endtask

  initial begin
    // Power-on reset
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // T1: reset mid-capture with level=5
    pulse_arm(1'b0, '0);
    chk("t1_state_cap", 32'(state), 32'd1);
    for (int n = 0; n < 5; n++) push(16'(n), 16'(n));
    chk("t1_level5", 32'(level), 32'd5);
    rst = 1'b1;
    #2;
    chk("t1_state", 32'(state), 32'd0);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_valid", 32'(rd_valid), 32'd0);
    chk("t1_ovf", 32'(ovf_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_after_state", 32'(state), 32'd0);

    // Writes in IDLE are discarded
    push(16'h1234, 16'h5678);
    chk("idle_push_level", 32'(level), 32'd0);

    // T2: one-shot of 8; later changes to one_shot/capture_len must be ignored
    pulse_arm(1'b1, 5'd8);
    one_shot = 1'b0;
    capture_len = 5'd3;
    for (int n = 0; n < 12; n++) begin
      push(16'(n), 16'(-n));
      if (n == 6) chk("t2_state_n6", 32'(state), 32'd1);
      if (n == 7) begin
        chk("t2_state_n7", 32'(state), 32'd2);
        chk("t2_level_n7", 32'(level), 32'd8);
      end
    end
    chk("t2_level", 32'(level), 32'd8);
    chk("t2_ovf", 32'(ovf_cnt), 32'd0);
    chk("t2_state", 32'(state), 32'd2);
    for (int n = 0; n < 8; n++) pop("t2_rd", {16'(n), 16'(-n)});
    chk("t2_empty_level", 32'(level), 32'd0);
    chk("t2_empty_valid", 32'(rd_valid), 32'd0);

    // rd_en on an empty FIFO is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty_pop_level", 32'(level), 32'd0);

    // T3: continuous, 20 writes into 16 slots, no reads
    pulse_arm(1'b0, '0);
    for (int n = 0; n < 20; n++) begin
      push(16'(100 + n), 16'(200 + n));
      if (n == 0) begin
        chk("t3_lat_valid0", 32'(rd_valid), 32'd0);
        chk("t3_lat_level1", 32'(level), 32'd1);
      end
      if (n == 1) begin
        chk("t3_lat_valid1", 32'(rd_valid), 32'd1);
        chk("t3_lat_data", rd_data, {16'd100, 16'd200});
      end
    end
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(ovf_cnt), 32'd4);
    // Overflow counter saturates at all-ones
    for (int n = 0; n < 4; n++) push(16'hdead, 16'hbeef);
    chk("t3_ovf_sat", 32'(ovf_cnt), 32'd7);

    // T4: push and pop together while full
    chk("t4_head", rd_data, {16'd100, 16'd200});
    in_x = 16'd300;
    in_y = 16'd400;
    ce_down = 1'b1;
    rd_en = 1'b1;
    tick();
    ce_down = 1'b0;
    rd_en = 1'b0;
    $display("push+pop x=300 y=400 level=%0d", level);
    chk("t4_level", 32'(level), 32'd16);
    chk("t4_ovf", 32'(ovf_cnt), 32'd7);
    chk("t4_full", 32'(full), 32'd1);
    for (int k = 1; k < 16; k++) pop("t4_rd", {16'(100 + k), 16'(200 + k)});
    pop("t4_rd_last", {16'd300, 16'd400});
    chk("t4_empty_level", 32'(level), 32'd0);
    chk("t4_empty_valid", 32'(rd_valid), 32'd0);
    chk("t4_empty_full", 32'(full), 32'd0);

    // T5: re-arm during CAPTURE with level=6 and a coincident ce_down and rd_en
    for (int n = 0; n < 6; n++) push(16'(10 + n), 16'(20 + n));
    chk("t5_level6", 32'(level), 32'd6);
    in_x = 16'd99;
    in_y = 16'd98;
    ce_down = 1'b1;
    rd_en = 1'b1;
    one_shot = 1'b0;
    capture_len = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    ce_down = 1'b0;
    rd_en = 1'b0;
    $display("re-arm with coincident push and pop");
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_valid", 32'(rd_valid), 32'd0);
    chk("t5_ovf", 32'(ovf_cnt), 32'd0);
    chk("t5_state", 32'(state), 32'd1);
    tick();
    chk("t5_level_late", 32'(level), 32'd0);
    chk("t5_valid_late", 32'(rd_valid), 32'd0);
    push(16'd55, 16'd66);
    tick();
    pop("t5_restart", {16'd55, 16'd66});

    // Stop keeps contents; IDLE writes are dropped silently; arm beats stop
    push(16'd1, 16'd2);
    push(16'd3, 16'd4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_level", 32'(level), 32'd2);
    push(16'd5, 16'd6);
    chk("stop_idle_level", 32'(level), 32'd2);
    chk("stop_idle_ovf", 32'(ovf_cnt), 32'd0);
    pop("stop_rd", {16'd1, 16'd2});
    stop = 1'b1;
    pulse_arm(1'b0, '0);
    stop = 1'b0;
    chk("armstop_state", 32'(state), 32'd1);
    chk("armstop_level", 32'(level), 32'd0);

    // T6: one-shot with capture_len=0 means a full DEPTH
    pulse_arm(1'b1, '0);
    for (int n = 0; n < 20; n++) begin
      push(16'(n), 16'(n + 1));
      if (n == 14) chk("t6_state_n14", 32'(state), 32'd1);
      if (n == 15) begin
        chk("t6_state_n15", 32'(state), 32'd2);
        chk("t6_level_n15", 32'(level), 32'd16);
      end
    end
    chk("t6_level", 32'(level), 32'd16);
    chk("t6_ovf", 32'(ovf_cnt), 32'd0);
    chk("t6_full", 32'(full), 32'd1);
    pop("t6_rd0", {16'd0, 16'd1});
    pop("t6_rd1", {16'd1, 16'd2});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Bound total run time so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
